// File: rtl/hls_perf_monitor.sv
// Hardware statistics monitor for HLS block-level handshakes.
// Per-channel FSM tracks transactions; counters saturate; results via a registered select port.
module hls_perf_monitor #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned CH_W   = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic              finish,
    input  logic [NUM_CH-1:0] ap_start,
    input  logic [NUM_CH-1:0] ap_ready,
    input  logic [NUM_CH-1:0] ap_done,
    input  logic [NUM_CH-1:0] ap_continue,
    input  logic [NUM_CH-1:0] iter_end,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [2:0]        rd_sel,
    output logic [CNT_W-1:0]  rd_data,
    output logic              frozen,
    output logic              any_sat
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, WAIT = 2'd2} state_e;

    state_e           state_q  [NUM_CH];
    state_e           state_d  [NUM_CH];
    logic [CNT_W-1:0] txn_q    [NUM_CH];
    logic [CNT_W-1:0] txn_d    [NUM_CH];
    logic [CNT_W-1:0] active_q [NUM_CH];
    logic [CNT_W-1:0] active_d [NUM_CH];
    logic [CNT_W-1:0] stall_q  [NUM_CH];
    logic [CNT_W-1:0] stall_d  [NUM_CH];
    logic [CNT_W-1:0] iter_q   [NUM_CH];
    logic [CNT_W-1:0] iter_d   [NUM_CH];
    logic [CNT_W-1:0] ready_q  [NUM_CH];
    logic [CNT_W-1:0] ready_d  [NUM_CH];
    logic [CNT_W-1:0] lat_q    [NUM_CH];
    logic [CNT_W-1:0] lat_d    [NUM_CH];
    logic [CNT_W-1:0] last_q   [NUM_CH];
    logic [CNT_W-1:0] last_d   [NUM_CH];
    logic [CNT_W-1:0] max_q    [NUM_CH];
    logic [CNT_W-1:0] max_d    [NUM_CH];
    logic [CNT_W-1:0] lat_done_c [NUM_CH];
    logic [NUM_CH-1:0] complete_c;
    logic [NUM_CH-1:0] accept_c;
    logic [NUM_CH-1:0] sat_q;
    logic [NUM_CH-1:0] sat_d;
    logic [CH_W-1:0]   rd_ch_q;
    logic [2:0]        rd_sel_q;
    logic [CNT_W-1:0]  rd_mux_c;
    logic              cnt_en_c;

    function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    assign cnt_en_c = enable & ~frozen & ~clear;

    // Next-state and next-counter values for every channel.
    always_comb begin
        complete_c = '0;
        accept_c   = '0;
        sat_d      = sat_q;
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c]    = state_q[c];
            lat_d[c]      = lat_q[c];
            lat_done_c[c] = inc_sat(lat_q[c]);
            case (state_q[c])
                IDLE: begin
                    if (ap_start[c]) begin
                        accept_c[c] = 1'b1;
                        if (ap_done[c]) begin
                            complete_c[c] = 1'b1;
                            lat_done_c[c] = CNT_W'(1);
                            state_d[c]    = ap_continue[c] ? IDLE : WAIT;
                        end else begin
                            lat_d[c]   = CNT_W'(1);
                            state_d[c] = RUN;
                        end
                    end
                end
                RUN: begin
                    if (ap_done[c]) begin
                        complete_c[c] = 1'b1;
                        state_d[c]    = ap_continue[c] ? IDLE : WAIT;
                    end else begin
                        lat_d[c] = inc_sat(lat_q[c]);
                    end
                end
                WAIT: begin
                    if (ap_continue[c]) state_d[c] = IDLE;
                end
                default: state_d[c] = IDLE;
            endcase
            txn_d[c]    = complete_c[c] ? inc_sat(txn_q[c]) : txn_q[c];
            active_d[c] = (state_q[c] != IDLE || accept_c[c]) ? inc_sat(active_q[c]) : active_q[c];
            stall_d[c]  = (state_q[c] == WAIT) ? inc_sat(stall_q[c]) : stall_q[c];
            iter_d[c]   = iter_end[c] ? inc_sat(iter_q[c]) : iter_q[c];
            ready_d[c]  = ap_ready[c] ? inc_sat(ready_q[c]) : ready_q[c];
            last_d[c]   = complete_c[c] ? lat_done_c[c] : last_q[c];
            max_d[c]    = (complete_c[c] && lat_done_c[c] > max_q[c]) ? lat_done_c[c] : max_q[c];
            if (txn_d[c] == CNT_MAX || active_d[c] == CNT_MAX || stall_d[c] == CNT_MAX ||
                iter_d[c] == CNT_MAX || ready_d[c] == CNT_MAX || last_d[c] == CNT_MAX ||
                max_d[c] == CNT_MAX) begin
                sat_d[c] = 1'b1;
            end
        end
    end

    // State and statistic registers; clear mirrors reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sat_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]  <= IDLE;
                txn_q[c]    <= '0;
                active_q[c] <= '0;
                stall_q[c]  <= '0;
                iter_q[c]   <= '0;
                ready_q[c]  <= '0;
                lat_q[c]    <= '0;
                last_q[c]   <= '0;
                max_q[c]    <= '0;
            end
        end else if (clear) begin
            sat_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]  <= IDLE;
                txn_q[c]    <= '0;
                active_q[c] <= '0;
                stall_q[c]  <= '0;
                iter_q[c]   <= '0;
                ready_q[c]  <= '0;
                lat_q[c]    <= '0;
                last_q[c]   <= '0;
                max_q[c]    <= '0;
            end
        end else if (cnt_en_c) begin
            sat_q <= sat_d;
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]  <= state_d[c];
                txn_q[c]    <= txn_d[c];
                active_q[c] <= active_d[c];
                stall_q[c]  <= stall_d[c];
                iter_q[c]   <= iter_d[c];
                ready_q[c]  <= ready_d[c];
                lat_q[c]    <= lat_d[c];
                last_q[c]   <= last_d[c];
                max_q[c]    <= max_d[c];
            end
        end
    end

    // Readout mux over the registered select; unmatched channels read as zero.
    always_comb begin
        rd_mux_c = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_ch_q == CH_W'(c)) begin
                case (rd_sel_q)
                    3'd0: rd_mux_c = txn_q[c];
                    3'd1: rd_mux_c = active_q[c];
                    3'd2: rd_mux_c = stall_q[c];
                    3'd3: rd_mux_c = iter_q[c];
                    3'd4: rd_mux_c = last_q[c];
                    3'd5: rd_mux_c = max_q[c];
                    3'd6: rd_mux_c = ready_q[c];
                    3'd7: rd_mux_c = CNT_W'({frozen, sat_q[c], state_q[c] == WAIT, state_q[c] == RUN});
                    default: rd_mux_c = '0;
                endcase
            end
        end
    end

    // Freeze flag, readout pipeline and saturation summary.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frozen   <= 1'b0;
            any_sat  <= 1'b0;
            rd_data  <= '0;
            rd_ch_q  <= '0;
            rd_sel_q <= '0;
        end else begin
            rd_ch_q  <= rd_ch;
            rd_sel_q <= rd_sel;
            if (clear) begin
                frozen  <= 1'b0;
                any_sat <= 1'b0;
                rd_data <= '0;
            end else begin
                if (finish) frozen <= 1'b1;
                any_sat <= |sat_q;
                rd_data <= rd_mux_c;
            end
        end
    end

endmodule
